sincos_arbiter: RTL and testbench

Shares one `sin_cos` quarter-wave lookup between NREQ requesters, such as the ship rotation, bullet launch vectors and asteroid drift setup. Each cycle the block picks at most one pending request, issues its phase to the lookup and tags it with the requester index. It returns the sine/cosine pair with that index after a fixed pipeline latency. It sits between the game-object update FSMs and the single ROM-backed `sin_cos` instance.

---
 rtl/sincos_arb_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 32 +++
 rtl/sin_cos.sv | 55 +++++
 rtl/sincos_arbiter.sv | 74 +++++++
 tb/tb_sincos_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sincos_arb_pkg.sv
// sincos_arb_pkg: default sizing, requester-id width helper and the in-flight tag type
// shared by sincos_arbiter and rr_arbiter.
package sincos_arb_pkg;
  localparam int NREQ = 4;
  localparam int ROM_DEPTH = 256;
  localparam int WIDTH = 18;
  localparam int LAT = 1;
  localparam int MAX_IDW = 3;
  function automatic int IDW(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction
  typedef struct packed {
    logic               valid;
    logic [MAX_IDW-1:0] id;
  } sincos_tag_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot grant, searching upward from rr with wrap to 0.
// SINCOS_ARB_FIXED_PRIO_EN selects fixed lowest-index-wins priority (rr ignored).
module rr_arbiter import sincos_arb_pkg::*; #(
  parameter int NREQ = sincos_arb_pkg::NREQ,
  localparam int IDW = sincos_arb_pkg::IDW(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  rr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_id
);
`ifdef SINCOS_ARB_FIXED_PRIO_EN
  logic unused_rr;
  assign unused_rr = ^rr;
  always_comb begin
    gnt_id = '0;
    for (int i = NREQ - 1; i >= 0; i--) gnt_id = req[i] ? IDW'(i) : gnt_id;
  end
`else
  logic [NREQ-1:0] rot;
  // Rotate so bit 0 is the requester at rr; the lowest set bit of rot wins.
  always_comb begin
    rot = NREQ'({req, req} >> rr);
    gnt_id = '0;
    for (int o = NREQ - 1; o >= 0; o--) gnt_id = rot[o] ? IDW'((int'(rr) + o) % NREQ) : gnt_id;
  end
`endif
  always_comb begin
    gnt = '0;
    gnt[gnt_id] = |req;
  end
endmodule

// File: rtl/sin_cos.sv
// sin_cos: quarter-wave ROM sine/cosine of a full-circle phase, result valid LAT cycles
// after the phase is presented; quadrant mirroring and sign are applied before the pipeline.
module sin_cos #(
  parameter int ROM_DEPTH = 256,
  parameter int WIDTH = 18,
  parameter int LAT = 1,
  localparam int ADDRW = $clog2(4 * ROM_DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDRW-1:0]        phase,
  output logic signed [WIDTH-1:0] sin_val,
  output logic signed [WIDTH-1:0] cos_val
);
  localparam int KW = ADDRW - 2;
  localparam logic [WIDTH-2:0] FULL = '1;
  localparam real HALF_PI = 1.5707963267948966;
  logic [WIDTH-2:0] rom [ROM_DEPTH];
  logic [1:0] q;
  logic [KW-1:0] k, kn;
  logic [WIDTH-2:0] m_fwd, m_rev, s_mag, c_mag;
  logic signed [WIDTH-1:0] s_lu, c_lu;
  logic signed [WIDTH-1:0] s_pipe [LAT];
  logic signed [WIDTH-1:0] c_pipe [LAT];
  for (genvar i = 0; i < ROM_DEPTH; i++) begin : g_rom
    assign rom[i] = (WIDTH-1)'($rtoi(FULL * $sin(HALF_PI * i / ROM_DEPTH) + 0.5));
  end
  // The mirrored read at k==0 lands on the quarter point, which the ROM does not store.
  always_comb begin
    {q, k} = phase;
    kn = -k;
    m_fwd = rom[k];
    m_rev = (k == '0) ? FULL : rom[kn];
    s_mag = q[0] ? m_rev : m_fwd;
    c_mag = q[0] ? m_fwd : m_rev;
    s_lu = q[1] ? -$signed({1'b0, s_mag}) : $signed({1'b0, s_mag});
    c_lu = (q[1] ^ q[0]) ? -$signed({1'b0, c_mag}) : $signed({1'b0, c_mag});
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) begin
        s_pipe[i] <= '0;
        c_pipe[i] <= '0;
      end
    end else begin
      s_pipe[0] <= s_lu;
      c_pipe[0] <= c_lu;
      for (int i = 1; i < LAT; i++) begin
        s_pipe[i] <= s_pipe[i-1];
        c_pipe[i] <= c_pipe[i-1];
      end
    end
  assign sin_val = s_pipe[LAT-1];
  assign cos_val = c_pipe[LAT-1];
endmodule

// File: rtl/sincos_arbiter.sv
// sincos_arbiter: shares one sin_cos lookup among NREQ requesters, returning id-tagged results.
// Define SINCOS_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module sincos_arbiter import sincos_arb_pkg::*; #(
  parameter int NREQ = sincos_arb_pkg::NREQ,
  parameter int ROM_DEPTH = sincos_arb_pkg::ROM_DEPTH,
  parameter int WIDTH = sincos_arb_pkg::WIDTH,
  parameter int LAT = sincos_arb_pkg::LAT,
  localparam int ADDRW = $clog2(4 * ROM_DEPTH),
  localparam int IDW = sincos_arb_pkg::IDW(NREQ)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NREQ-1:0]             req,
  input  logic [NREQ-1:0][ADDRW-1:0]  phase,
  output logic [NREQ-1:0]             ack,
  output logic                        rsp_valid,
  output logic [IDW-1:0]              rsp_id,
  output logic signed [WIDTH-1:0]     sin_val,
  output logic signed [WIDTH-1:0]     cos_val
);
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0] gnt_id, rr;
  logic accept;
  logic [ADDRW-1:0] phase_q;
  logic signed [WIDTH-1:0] lu_sin, lu_cos;
  sincos_tag_t tag [LAT+1];
  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req    (req),
    .rr     (rr),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );
  assign ack = rst_n ? gnt : '0;
  assign accept = |ack;
`ifdef SINCOS_ARB_FIXED_PRIO_EN
  assign rr = '0;
`else
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rr <= '0;
    else if (accept) rr <= (int'(gnt_id) == NREQ - 1) ? '0 : gnt_id + 1'b1;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) phase_q <= '0;
    else if (accept) phase_q <= phase[gnt_id];
  // Tag stage LAT lines up with the sin_cos output for the phase latched alongside tag stage 0.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i <= LAT; i++) tag[i] <= '0;
    end else begin
      tag[0] <= '{valid: accept, id: MAX_IDW'(gnt_id)};
      for (int i = 1; i <= LAT; i++) tag[i] <= tag[i-1];
    end
  sin_cos #(.ROM_DEPTH(ROM_DEPTH), .WIDTH(WIDTH), .LAT(LAT)) u_lut (
    .clk     (clk),
    .rst_n   (rst_n),
    .phase   (phase_q),
    .sin_val (lu_sin),
    .cos_val (lu_cos)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_id <= '0;
      sin_val <= '0;
      cos_val <= '0;
    end else begin
      rsp_valid <= tag[LAT].valid;
      if (tag[LAT].valid) begin
        rsp_id <= IDW'(tag[LAT].id);
        sin_val <= lu_sin;
        cos_val <= lu_cos;
      end
    end
endmodule

// File: tb/tb_sincos_arbiter.sv
// tb_sincos_arbiter: directed and randomized checks of sincos_arbiter against a reference model
// of grant order, response timing and real-valued sine/cosine.
`timescale 1ns/1ps
module tb_sincos_arbiter;
  localparam int LAT = 1;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] req = '0;
  logic [3:0][9:0] phase = '0;
  logic [3:0] ack;
  logic rsp_valid;
  logic [1:0] rsp_id;
  logic signed [17:0] sin_val, cos_val;
  int checks = 0, failures = 0, cyc = 0, rr_m = 0, exp_g;
  typedef struct { int due; int id; int ph; } rsp_t;
  rsp_t exp_q[$];
  logic [3:0] obs_ack, exp_ack;
  logic obs_rv, exp_rv;
  int obs_id, obs_s, obs_c, exp_id, exp_s, exp_c;

  sincos_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .phase     (phase),
    .ack       (ack),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .sin_val   (sin_val),
    .cos_val   (cos_val)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  function automatic int gold(input int ph, input bit want_cos);
    real a;
    a = 131071.0 * (want_cos ? $cos(6.283185307179586 * ph / 1024.0) : $sin(6.283185307179586 * ph / 1024.0));
    return (a >= 0.0) ? $rtoi(a + 0.5) : -$rtoi(0.5 - a);
  endfunction

  // One clock: predicts the grant, samples ack, then samples the response of the next cycle.
  task automatic tick(input logic [3:0] r, input logic [3:0][9:0] p);
    req = r;
    phase = p;
    #1;
    exp_g = -1;
`ifdef SINCOS_ARB_FIXED_PRIO_EN
    for (int i = 3; i >= 0; i--) if (r[2'(i)]) exp_g = i;
`else
    for (int o = 3; o >= 0; o--) if (r[2'((rr_m + o) % 4)]) exp_g = (rr_m + o) % 4;
`endif
    exp_ack = (exp_g < 0) ? 4'b0 : 4'(1 << exp_g);
    obs_ack = ack;
    @(posedge clk);
    if (exp_g >= 0) begin
      exp_q.push_back('{cyc + LAT + 2, exp_g, int'(p[2'(exp_g)])});
      rr_m = (exp_g + 1) % 4;
    end
    cyc++;
    @(negedge clk);
    exp_rv = 1'b0;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      exp_rv = 1'b1;
      exp_id = exp_q[0].id;
      exp_s = gold(exp_q[0].ph, 1'b0);
      exp_c = gold(exp_q[0].ph, 1'b1);
      void'(exp_q.pop_front());
    end
    obs_rv = rsp_valid;
    obs_id = int'(rsp_id);
    obs_s = int'(sin_val);
    obs_c = int'(cos_val);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    rr_m = 0;
    cyc = 0;
    exp_id = 0;
    exp_s = 0;
    exp_c = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req = 4'b1111;
    repeat (2) @(negedge clk);
    #1;
    checks += 2;
    if (ack !== 4'b0) begin
      failures++;
      $display("FAIL reset_ack got=%b want=0000", ack);
    end
    if (rsp_valid !== 1'b0 || rsp_id !== 2'd0 || sin_val !== 18'sd0 || cos_val !== 18'sd0) begin
      failures++;
      $display("FAIL reset_outputs got v=%b id=%0d sin=%0d cos=%0d want all 0", rsp_valid, rsp_id, sin_val, cos_val);
    end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    for (int t = 0; t < 5; t++) begin
      tick((t == 0) ? 4'b0001 : 4'b0000, '0);
      checks += 2;
      if (obs_ack !== exp_ack || (t == 0 && obs_ack !== 4'b0001)) begin
        failures++;
        $display("FAIL single_ack t=%0d got=%b want=%b", t, obs_ack, exp_ack);
      end
      if (obs_rv !== exp_rv || obs_id != exp_id || obs_s != exp_s || obs_c != exp_c) begin
        failures++;
        $display("FAIL single_rsp cyc=%0d got v=%b id=%0d sin=%0d cos=%0d want v=%b id=%0d sin=%0d cos=%0d",
                 cyc, obs_rv, obs_id, obs_s, obs_c, exp_rv, exp_id, exp_s, exp_c);
      end
    end
  endtask

  task automatic test_all_active();
    int cnt [4];
    int pulses;
    logic [3:0][9:0] p;
    p = {10'd768, 10'd512, 10'd256, 10'd0};
    cnt = '{0, 0, 0, 0};
    pulses = 0;
    do_reset();
    for (int t = 0; t < 12; t++) begin
      tick((t < 8) ? 4'b1111 : 4'b0000, p);
      for (int i = 0; i < 4; i++) cnt[i] += int'(obs_ack[i]);
      pulses += int'(obs_rv);
      checks += 2;
      if (obs_ack !== exp_ack) begin
        failures++;
        $display("FAIL all_ack t=%0d got=%b want=%b", t, obs_ack, exp_ack);
      end
      if (obs_rv !== exp_rv || obs_id != exp_id || obs_s != exp_s || obs_c != exp_c) begin
        failures++;
        $display("FAIL all_rsp cyc=%0d got v=%b id=%0d sin=%0d cos=%0d want v=%b id=%0d sin=%0d cos=%0d",
                 cyc, obs_rv, obs_id, obs_s, obs_c, exp_rv, exp_id, exp_s, exp_c);
      end
    end
    for (int i = 0; i < 4; i++) begin
      int want;
`ifdef SINCOS_ARB_FIXED_PRIO_EN
      want = (i == 0) ? 8 : 0;
`else
      want = 2;
`endif
      checks++;
      if (cnt[i] != want) begin
        failures++;
        $display("FAIL all_fairness id=%0d grants=%0d want=%0d", i, cnt[i], want);
      end
    end
    checks++;
    if (pulses != 8) begin
      failures++;
      $display("FAIL all_pulses got=%0d want=8", pulses);
    end
  endtask

  task automatic test_wrap_edge();
    int acks, hits;
    logic [3:0][9:0] p;
    p = '0;
    p[2] = 10'd1023;
    acks = 0;
    hits = 0;
    do_reset();
    for (int t = 0; t < 9; t++) begin
      tick((t < 5) ? 4'b0100 : 4'b0000, p);
      acks += int'(obs_ack[2]);
      hits += int'(obs_rv === 1'b1 && obs_id == 2);
      checks += 2;
      if (obs_ack !== exp_ack) begin
        failures++;
        $display("FAIL wrap_ack t=%0d got=%b want=%b", t, obs_ack, exp_ack);
      end
      if (obs_rv !== exp_rv || obs_id != exp_id || obs_s != exp_s || obs_c != exp_c) begin
        failures++;
        $display("FAIL wrap_rsp cyc=%0d got v=%b id=%0d sin=%0d cos=%0d want v=%b id=%0d sin=%0d cos=%0d",
                 cyc, obs_rv, obs_id, obs_s, obs_c, exp_rv, exp_id, exp_s, exp_c);
      end
    end
    checks++;
    if (acks != 5 || hits != 5) begin
      failures++;
      $display("FAIL wrap_count acks=%0d rsps=%0d want 5 and 5", acks, hits);
    end
  endtask

  task automatic test_reset_inflight();
    logic [3:0][9:0] p;
    p = {10'd300, 10'd200, 10'd150, 10'd100};
    do_reset();
    for (int t = 0; t < 4; t++) tick(4'b1111, p);
    checks++;
    if (obs_rv !== 1'b1 || obs_s != exp_s || obs_c != exp_c) begin
      failures++;
      $display("FAIL inflight_pre got v=%b sin=%0d cos=%0d want v=1 sin=%0d cos=%0d", obs_rv, obs_s, obs_c, exp_s, exp_c);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (ack !== 4'b0 || rsp_valid !== 1'b0 || rsp_id !== 2'd0 || sin_val !== 18'sd0 || cos_val !== 18'sd0) begin
      failures++;
      $display("FAIL inflight_clear got ack=%b v=%b id=%0d sin=%0d cos=%0d want all 0", ack, rsp_valid, rsp_id, sin_val, cos_val);
    end
    do_reset();
    for (int t = 0; t < 6; t++) begin
      tick(4'b0000, p);
      checks++;
      if (obs_rv !== 1'b0 || obs_id != 0 || obs_s != 0 || obs_c != 0) begin
        failures++;
        $display("FAIL inflight_quiet cyc=%0d got v=%b id=%0d sin=%0d cos=%0d want v=0 id=0 sin=0 cos=0",
                 cyc, obs_rv, obs_id, obs_s, obs_c);
      end
    end
  endtask

  task automatic test_withdraw();
    logic [3:0][9:0] p;
    p = {10'd40, 10'd30, 10'd20, 10'd10};
    do_reset();
    for (int t = 0; t < 8; t++) begin
      tick((t == 0) ? 4'b0011 : (t < 5) ? 4'b0001 : 4'b0000, p);
      checks += 2;
      if (obs_ack !== exp_ack || obs_ack[1] !== 1'b0) begin
        failures++;
        $display("FAIL withdraw_ack t=%0d got=%b want=%b", t, obs_ack, exp_ack);
      end
      if (obs_rv !== exp_rv || obs_id != exp_id || obs_s != exp_s || obs_c != exp_c || (obs_rv === 1'b1 && obs_id == 1)) begin
        failures++;
        $display("FAIL withdraw_rsp cyc=%0d got v=%b id=%0d sin=%0d cos=%0d want v=%b id=%0d sin=%0d cos=%0d",
                 cyc, obs_rv, obs_id, obs_s, obs_c, exp_rv, exp_id, exp_s, exp_c);
      end
    end
  endtask

`ifdef SINCOS_ARB_FIXED_PRIO_EN
  task automatic test_fixed_prio();
    do_reset();
    for (int t = 0; t < 8; t++) begin
      tick((t < 4) ? 4'b0110 : 4'b0000, {10'd0, 10'd512, 10'd256, 10'd0});
      checks += 2;
      if (obs_ack !== exp_ack || (t < 4 && obs_ack !== 4'b0010)) begin
        failures++;
        $display("FAIL fixed_ack t=%0d got=%b want=%b", t, obs_ack, exp_ack);
      end
      if (obs_rv !== exp_rv || obs_id != exp_id || obs_s != exp_s || obs_c != exp_c || (obs_rv === 1'b1 && obs_id == 2)) begin
        failures++;
        $display("FAIL fixed_rsp cyc=%0d got v=%b id=%0d want v=%b id=%0d", cyc, obs_rv, obs_id, exp_rv, exp_id);
      end
    end
  endtask
`endif

  task automatic test_random();
    logic [3:0] pend;
    logic [3:0][9:0] p;
    pend = '0;
    p = '0;
    do_reset();
    for (int t = 0; t < 304; t++) begin
      for (int i = 0; i < 4; i++) begin
        if (t >= 300) pend[i] = 1'b0;
        else if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          p[i] = 10'($urandom_range(0, 1023));
        end else if (pend[i] && $urandom_range(0, 9) == 0) pend[i] = 1'b0;
      end
      tick(pend, p);
      if (exp_g >= 0) pend[2'(exp_g)] = 1'b0;
      checks += 2;
      if (obs_ack !== exp_ack) begin
        failures++;
        $display("FAIL random_ack t=%0d got=%b want=%b", t, obs_ack, exp_ack);
      end
      if (obs_rv !== exp_rv || obs_id != exp_id || obs_s != exp_s || obs_c != exp_c) begin
        failures++;
        $display("FAIL random_rsp cyc=%0d got v=%b id=%0d sin=%0d cos=%0d want v=%b id=%0d sin=%0d cos=%0d",
                 cyc, obs_rv, obs_id, obs_s, obs_c, exp_rv, exp_id, exp_s, exp_c);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_active();
    test_wrap_edge();
    test_reset_inflight();
    test_withdraw();
`ifdef SINCOS_ARB_FIXED_PRIO_EN
    test_fixed_prio();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
